// File: rtl/mux_sel_reg_n.sv
// Registered N-channel selector with valid/ready output stage.
// Direct mode captures a requested channel; scan mode walks enabled channels round-robin.
module mux_sel_reg_n #(
   parameter int WIDTH      = 5,
   parameter int CHANNELS   = 11,
   parameter int SEL_W      = $clog2(CHANNELS),
   parameter int DEFAULT_CH = 9
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      mode,
   input  logic [SEL_W-1:0]          sel,
   input  logic                      sel_valid,
   output logic                      sel_ready,
   input  logic [CHANNELS-1:0]       ch_en,
   input  logic [CHANNELS*WIDTH-1:0] data_in,
   input  logic                      out_ready,
   output logic [WIDTH-1:0]          out_data,
   output logic                      out_valid,
   output logic [SEL_W-1:0]          out_ch,
   output logic                      sel_err
);

   logic [SEL_W-1:0] ptr;
   logic             ld;
   logic             scan_found;
   logic [SEL_W-1:0] scan_ch;
   logic [SEL_W-1:0] scan_next;
   logic             cap_en;
   logic [SEL_W-1:0] cap_ch;
   logic             cap_err;
   logic [WIDTH-1:0] cap_data;

   assign ld        = !out_valid || out_ready;
   assign sel_ready = ld;

   // First enabled channel at or above ptr, wrapping modulo CHANNELS.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path infers a latch.
      scan_found = 1'b0;
      scan_ch    = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         int idx;
         idx = int'(ptr) + i;
         if (idx >= CHANNELS) idx = idx - CHANNELS;
         if (!scan_found && ch_en[idx]) begin
            scan_found = 1'b1;
            scan_ch    = SEL_W'(idx);
         end
      end
   end

   assign scan_next = (int'(scan_ch) == CHANNELS - 1) ? '0 : scan_ch + 1'b1;

   always_comb begin
      cap_en  = 1'b0;
      cap_ch  = '0;
      cap_err = 1'b0;
      if (mode) begin
         cap_en = scan_found;
         cap_ch = scan_ch;
      end else begin
         cap_en = sel_valid;
         if (int'(sel) >= CHANNELS) begin
            cap_ch  = SEL_W'(DEFAULT_CH);
            cap_err = 1'b1;
         end else begin
            cap_ch = sel;
         end
      end
   end

   // Explicit compare mux keeps the index in range whatever SEL_W allows.
   always_comb begin
      cap_data = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         if (cap_ch == SEL_W'(k)) cap_data = data_in[k*WIDTH +: WIDTH];
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_data  <= '0;
         out_valid <= 1'b0;
         out_ch    <= '0;
         sel_err   <= 1'b0;
         ptr       <= '0;
      end else begin
         if (ld) begin
            out_valid <= cap_en;
            if (cap_en) begin
               out_data <= cap_data;
               out_ch   <= cap_ch;
               sel_err  <= cap_err;
            end
         end
         // Direct mode parks the pointer so a later scan always starts at channel 0.
         if (!mode)
            ptr <= '0;
         else if (ld && scan_found)
            ptr <= scan_next;
      end
   end

endmodule

// File: tb/tb_mux_sel_reg_n.sv
// Directed self-checking bench for mux_sel_reg_n at default parameters.
// Channel k carries the value k+3; each step checks registered outputs #1 after the edge.
module tb_mux_sel_reg_n;

   localparam int WIDTH    = 5;
   localparam int CHANNELS = 11;
   localparam int SEL_W    = 4;

   logic                      clk = 1'b0;
   logic                      rst;
   logic                      mode;
   logic [SEL_W-1:0]          sel;
   logic                      sel_valid;
   logic                      sel_ready;
   logic [CHANNELS-1:0]       ch_en;
   logic [CHANNELS*WIDTH-1:0] data_in;
   logic                      out_ready;
   logic [WIDTH-1:0]          out_data;
   logic                      out_valid;
   logic [SEL_W-1:0]          out_ch;
   logic                      sel_err;

   int checks = 0;
   int errors = 0;

   mux_sel_reg_n dut (
      .clk       (clk),
      .rst       (rst),
      .mode      (mode),
      .sel       (sel),
      .sel_valid (sel_valid),
      .sel_ready (sel_ready),
      .ch_en     (ch_en),
      .data_in   (data_in),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ch    (out_ch),
      .sel_err   (sel_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_word(input string tag, input int ch, input int data, input logic err);
      check({tag, " valid"}, 32'(out_valid), 32'd1);
      check({tag, " ch"},    32'(out_ch),    32'(ch));
      check({tag, " data"},  32'(out_data),  32'(data));
      check({tag, " err"},   32'(sel_err),   32'(err));
   endtask

   initial begin
      int scan_seq[5];
      scan_seq = '{1, 5, 10, 1, 5};

      for (int k = 0; k < CHANNELS; k++) data_in[k*WIDTH +: WIDTH] = WIDTH'(k + 3);
      rst = 1'b1; mode = 1'b0; sel = 4'd4; sel_valid = 1'b1;
      out_ready = 1'b1; ch_en = '0;

      // 1. reset held two cycles with a pending request
      tick(); tick();
      check("rst valid", 32'(out_valid), 32'd0);
      check("rst data",  32'(out_data),  32'd0);
      check("rst ch",    32'(out_ch),    32'd0);
      check("rst err",   32'(sel_err),   32'd0);
      rst = 1'b0;
      tick();
      expect_word("first cap", 4, 7, 1'b0);

      // 2. direct select of every channel back to back
      for (int s = 0; s < CHANNELS; s++) begin
         sel = SEL_W'(s);
         tick();
         expect_word($sformatf("direct%0d", s), s, s + 3, 1'b0);
      end

      // 3. out-of-range select falls back to channel 9
      sel = 4'd13;
      tick();
      expect_word("oor", 9, 12, 1'b1);
      sel = 4'd2;
      tick();
      expect_word("after oor", 2, 5, 1'b0);

      // 4. backpressure holds the word and blocks new captures
      sel = 4'd3;
      tick();
      expect_word("bp cap", 3, 6, 1'b0);
      out_ready = 1'b0; sel = 4'd7;
      #1;
      check("bp ready low", 32'(sel_ready), 32'd0);
      for (int i = 0; i < 4; i++) begin
         tick();
         expect_word($sformatf("bp hold%0d", i), 3, 6, 1'b0);
         check("bp ready", 32'(sel_ready), 32'd0);
      end
      out_ready = 1'b1;
      #1;
      check("bp ready high", 32'(sel_ready), 32'd1);
      tick();
      expect_word("bp release", 7, 10, 1'b0);
      sel_valid = 1'b0;
      tick();
      check("direct idle valid", 32'(out_valid), 32'd0);

      // 5. scan over channels {1,5,10} with wrap
      mode = 1'b1;
      ch_en = 11'b100_0010_0010;
      for (int i = 0; i < 5; i++) begin
         tick();
         expect_word($sformatf("scan%0d", i), scan_seq[i], scan_seq[i] + 3, 1'b0);
      end
      out_ready = 1'b0; ch_en = '0;
      tick();
      expect_word("scan held", 5, 8, 1'b0);
      out_ready = 1'b1;
      tick();
      check("scan empty valid", 32'(out_valid), 32'd0);

      // 6. pointer kept at 6; mode switch then reset restart the scan at 0
      ch_en = '1;
      tick();
      expect_word("resume ptr6", 6, 9, 1'b0);
      mode = 1'b0;
      tick();
      check("switch direct valid", 32'(out_valid), 32'd0);
      mode = 1'b1;
      tick();
      expect_word("rescan0", 0, 3, 1'b0);
      tick();
      expect_word("rescan1", 1, 4, 1'b0);
      rst = 1'b1;
      tick();
      check("midrst valid", 32'(out_valid), 32'd0);
      check("midrst data",  32'(out_data),  32'd0);
      check("midrst ch",    32'(out_ch),    32'd0);
      rst = 1'b0;
      tick();
      expect_word("postrst0", 0, 3, 1'b0);
      tick();
      expect_word("postrst1", 1, 4, 1'b0);

      // single enabled channel repeats every cycle
      ch_en = 11'b000_0001_0000;
      tick();
      expect_word("single a", 4, 7, 1'b0);
      tick();
      expect_word("single b", 4, 7, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mux_sel_reg_n.md
Name: mux_sel_reg_n

Overview:
Parametrised, registered N-channel selector, succeeding the fixed 11-input combinational selector used in the decryption datapath. It has a flattened channel bus with configurable width and channel count, and a configurable fallback channel for out-of-range selects. It adds a one-stage output register with a valid/ready handshake and a round-robin scan mode that walks the enabled channels autonomously. It sits between the datapath register sources and downstream consumers (ALU operand path, pixel writer).

Parameters:
WIDTH, 5, bit width of each channel
CHANNELS, 11, number of input channels (>=2)
SEL_W, $clog2(CHANNELS), select/pointer width (derived; do not override)
DEFAULT_CH, 9, channel used when a direct select is >= CHANNELS (must be < CHANNELS)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous reset, active-high
mode  in  1  0 = direct select, 1 = round-robin scan
sel  in  SEL_W  channel index, direct mode only
sel_valid  in  1  request a capture of channel sel (direct mode)
sel_ready  out  1  capture accepted this cycle = !out_valid || out_ready (combinational)
ch_en  in  CHANNELS  per-channel enable mask, scan mode only
data_in  in  CHANNELS*WIDTH  flattened inputs; channel k = data_in[k*WIDTH +: WIDTH]
out_ready  in  1  downstream accepts out_data this cycle
out_data  out  WIDTH  registered selected data
out_valid  out  1  out_data holds an unconsumed word
out_ch  out  SEL_W  channel index actually captured
sel_err  out  1  registered with out_data; 1 when the capture used the DEFAULT_CH fallback

Behaviour:
- Reset (rst=1 at a clock edge): out_data=0, out_valid=0, out_ch=0, sel_err=0, scan pointer ptr=0. rst overrides all other inputs in that cycle.
- Load enable: ld = !out_valid || out_ready. Equals sel_ready.
- Hold: out_valid=1 and out_ready=0 holds out_data, out_ch, sel_err and ptr stable. sel_valid is ignored, and no capture is lost: the requester must keep sel_valid asserted until sel_ready.
- Latency: one cycle. data_in is sampled at the capture edge, and the result is visible the following cycle.
- Direct mode (mode=0):
  - ld && sel_valid: capture channel sel. If sel >= CHANNELS, capture DEFAULT_CH instead, set out_ch=DEFAULT_CH and sel_err=1; otherwise sel_err=0. Set out_valid=1.
  - ld && !sel_valid: out_valid <= 0.
  - ptr is forced to 0 every cycle while mode=0.
- Scan mode (mode=1): sel and sel_valid are ignored.
  - When ld: search from ptr upward, wrapping modulo CHANNELS, for the first k with ch_en[k]=1.
  - Channel found: capture channel k, out_ch=k, sel_err=0, out_valid=1, ptr <= (k+1) mod CHANNELS. A pointer at CHANNELS-1 wraps to 0.
  - ch_en all zero: out_valid <= 0, ptr unchanged.
  - A single enabled channel is captured on every ld cycle.
  - ch_en changes take effect at the next ld. A word already in the output register is unaffected.
- Mode switch: takes effect on the next ld cycle. A held word completes its handshake under the old mode. Entering scan mode always starts the search at channel 0.
- Throughput: one word per cycle when out_ready is held at 1. No bubbles in scan mode while at least one channel is enabled.
- Out-of-range indices cannot arise in scan mode. The pointer never exceeds CHANNELS-1.
- Purely synchronous. No latches. No combinational path from data_in to outputs.

Test Plan:
All scenarios use defaults (WIDTH=5, CHANNELS=11, DEFAULT_CH=9) and channel k driven with value k+3.
1. Reset: assert rst 2 cycles with sel_valid=1, sel=4 -> out_valid=0, out_data=0, out_ch=0, sel_err=0. First capture happens only after rst drops.
2. Direct select: mode=0, out_ready=1, sel=0..10 on consecutive cycles with sel_valid=1 -> each following cycle out_data=sel+3, out_ch=sel, sel_err=0, out_valid=1 continuously.
3. Out-of-range: sel=13, sel_valid=1 -> next cycle out_data=12, out_ch=9, sel_err=1. Then sel=2 -> out_data=5, sel_err=0.
4. Backpressure: capture sel=3, then out_ready=0 for 4 cycles while sel changes to 7 -> out_data stays 6 and sel_ready=0. On out_ready=1, sel=7 is captured the next cycle (out_data=10).
5. Scan wrap: mode=1, ch_en=bits {1,5,10}, out_ready=1 -> out_ch sequence 1,5,10,1,5,... with out_data 4,8,13. Clearing ch_en to 0 -> out_valid drops after the current word is consumed.
6. Mode switch and reset mid-scan: scanning at ptr=6, switch to mode=0 then back to 1 with ch_en all ones -> out_ch restarts at 0. Asserting rst mid-scan -> outputs cleared next cycle, and the scan restarts at channel 0.
